// File: rtl/apb_master_pkg.sv
// ============================================================================
// Module      : apb_master_pkg
// Description : Shared state encoding, default widths and index-width helper
//               for the round-robin APB master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_master_pkg;

    localparam int c_NREQ_DEF = 2;
    localparam int c_AW_DEF   = 8;
    localparam int c_DW_DEF   = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // Bits needed to index n requesters, never less than one.
    function automatic int idx_width(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/apb_rr_master_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick: first set request at or
//               above the pointer, wrapping modulo NREQ.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_vld
);

    // Scan offsets from farthest to nearest so the nearest set bit wins last.
    always_comb begin
        int k;
        k       = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            k = (int'(ptr) + off) % NREQ;
            if (req[k]) begin
                gnt     = '0;
                gnt[k]  = 1'b1;
                gnt_idx = IW'(k);
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/apb_rr_master.sv
// ============================================================================
// Module      : apb_rr_master
// Description : Round-robin arbitrated APB master sharing one slave port
//               among NREQ requesters. Optional ACCESS-phase timeout is
//               enabled with the APB_TIMEOUT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_rr_master
    import apb_master_pkg::*;
#(
    parameter int NREQ           = c_NREQ_DEF,
    parameter int AW             = c_AW_DEF,
    parameter int DW             = c_DW_DEF,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]  done,
    output logic [DW-1:0]    rsp_rdata,
    output logic             rsp_err,
    output logic             psel,
    output logic             penable,
    output logic             pwrite,
    output logic [AW-1:0]    paddr,
    output logic [DW-1:0]    pwdata,
    input  logic [DW-1:0]    prdata,
    input  logic             pready
);

    localparam int c_IW = idx_width(NREQ);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("apb_rr_master: NREQ must be 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_rr_master: TIMEOUT_CYCLES must be at least 1");
    end

    state_t            r_state;
    logic [c_IW-1:0]   r_ptr;
    logic [NREQ-1:0]   r_gnt;

    logic [NREQ-1:0]   w_gnt;
    logic [c_IW-1:0]   w_gnt_idx;
    logic              w_gnt_vld;
    logic [c_IW-1:0]   w_next_ptr;
    logic [AW-1:0]     w_sel_addr;
    logic [DW-1:0]     w_sel_wdata;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (c_IW)
    ) u_arb (
        .req     (req),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .gnt_vld (w_gnt_vld)
    );

    assign w_next_ptr  = (w_gnt_idx == c_IW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    assign w_sel_addr  = req_addr[int'(w_gnt_idx)*AW +: AW];
    assign w_sel_wdata = req_wdata[int'(w_gnt_idx)*DW +: DW];

`ifdef APB_TIMEOUT_EN
    localparam int c_TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TW-1:0] r_tcnt;
    logic            r_err;
    assign rsp_err = r_err;
`else
    assign rsp_err = 1'b0;
`endif

    // paddr/pwrite/pwdata double as the payload latches for the granted requester.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_gnt     <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            done      <= '0;
            rsp_rdata <= '0;
`ifdef APB_TIMEOUT_EN
            r_tcnt    <= '0;
            r_err     <= 1'b0;
`endif
        end else begin
            done <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_vld) begin
                        r_gnt   <= w_gnt;
                        r_ptr   <= w_next_ptr;
                        pwrite  <= req_write[w_gnt_idx];
                        paddr   <= w_sel_addr;
                        pwdata  <= w_sel_wdata;
                        psel    <= 1'b1;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable <= 1'b1;
                    r_state <= ST_ACCESS;
`ifdef APB_TIMEOUT_EN
                    r_tcnt  <= '0;
`endif
                end
                ST_ACCESS: begin
                    if (pready) begin
                        if (!pwrite) rsp_rdata <= prdata;
                        done    <= r_gnt;
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        r_state <= ST_IDLE;
`ifdef APB_TIMEOUT_EN
                        r_err   <= 1'b0;
                    end else if (r_tcnt == c_TW'(TIMEOUT_CYCLES - 1)) begin
                        done    <= r_gnt;
                        r_err   <= 1'b1;
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_tcnt  <= r_tcnt + 1'b1;
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_apb_rr_master.sv
// ============================================================================
// Module      : tb_apb_rr_master
// Description : Scoreboard bench for apb_rr_master with a 16x8 APB slave
//               model; timeout vector runs when APB_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_rr_master;

    logic        pclk = 1'b0;
    logic        preset;
    logic [1:0]  req, req_write;
    logic [15:0] req_addr, req_wdata;
    logic [1:0]  done;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        psel, penable, pwrite;
    logic [7:0]  paddr, pwdata, prdata;
    logic        pready;

    apb_rr_master #(
        .NREQ           (2),
        .AW             (8),
        .DW             (8),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .pclk      (pclk),
        .preset    (preset),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .done      (done),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready)
    );

    always #5 pclk = ~pclk;

    // Register-memory slave with a programmable number of wait states.
    logic [7:0] mem [16];
    int         wait_states = 0;
    int         wcnt = 0;

    assign prdata = mem[paddr[3:0]];
    assign pready = psel && penable && (wcnt >= wait_states);

    always @(posedge pclk) begin
        if (psel && !penable) wcnt <= 0;
        else if (psel && penable && !pready) wcnt <= wcnt + 1;
        if (psel && penable && pready && pwrite) mem[paddr[3:0]] <= pwdata;
    end

    typedef struct packed {
        logic [1:0] done;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    exp_t mon_e;
    always @(negedge pclk) begin
        if (preset === 1'b0 && done !== 2'b00) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'h0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_done",  32'(done),      32'(mon_e.done));
                check("sb_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
                check("sb_err",   32'(rsp_err),   32'(mon_e.err));
            end
        end
    end

    task automatic tick();
        @(negedge pclk);
    endtask

    task automatic wait_done(input string name, input int maxc, output int n);
        n = -1;
        for (int i = 1; i <= maxc; i++) begin
            if (n < 0) begin
                tick();
                if (done !== 2'b00) n = i;
            end
        end
        if (n < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no done, expected done within %0d cycles", name, maxc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        preset    = 1'b1;
        req       = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[7] = 8'hC3;

        repeat (3) tick();
        check("rst_psel",    32'(psel),      0);
        check("rst_penable", 32'(penable),   0);
        check("rst_pwrite",  32'(pwrite),    0);
        check("rst_paddr",   32'(paddr),     0);
        check("rst_pwdata",  32'(pwdata),    0);
        check("rst_done",    32'(done),      0);
        check("rst_rdata",   32'(rsp_rdata), 0);
        check("rst_err",     32'(rsp_err),   0);
        preset = 1'b0;
        tick();

        // Single write from requester 0.
        req_addr[7:0]  = 8'h03;
        req_wdata[7:0] = 8'h5A;
        req_write[0]   = 1'b1;
        req            = 2'b01;
        sb.push_back('{2'b01, 8'h00, 1'b0});
        tick();
        check("t1_setup_psel",    32'(psel),    1);
        check("t1_setup_penable", 32'(penable), 0);
        check("t1_setup_paddr",   32'(paddr),   32'h03);
        check("t1_setup_pwrite",  32'(pwrite),  1);
        check("t1_setup_pwdata",  32'(pwdata),  32'h5A);
        tick();
        check("t1_access_psel",    32'(psel),    1);
        check("t1_access_penable", 32'(penable), 1);
        check("t1_access_done",    32'(done),    0);
        tick();
        check("t1_done_at_3", 32'(done), 32'h1);
        req = 2'b00;
        tick();
        check("t1_psel_after", 32'(psel), 0);

        // Read back through requester 1.
        req_addr[15:8] = 8'h03;
        req_write[1]   = 1'b0;
        req            = 2'b10;
        sb.push_back('{2'b10, 8'h5A, 1'b0});
        wait_done("t2", 10, n);
        check("t2_latency", n, 3);
        req = 2'b00;
        tick();

        // Contention from reset: grants alternate starting with requester 0.
        preset = 1'b1;
        tick();
        preset = 1'b0;
        req_addr[7:0]  = 8'h03;
        req_addr[15:8] = 8'h07;
        req_write      = 2'b00;
        sb.push_back('{2'b01, 8'h5A, 1'b0});
        sb.push_back('{2'b10, 8'hC3, 1'b0});
        sb.push_back('{2'b01, 8'h5A, 1'b0});
        sb.push_back('{2'b10, 8'hC3, 1'b0});
        req = 2'b11;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            if (k < 4) begin
                tick();
                if (done !== 2'b00) begin
                    k++;
                    if (k == 4) req = 2'b00;
                end
            end
        end
        req = 2'b00;
        check("t3_count", k, 4);
        tick();

        // Three wait states on a write.
        wait_states    = 3;
        req_addr[7:0]  = 8'h09;
        req_wdata[7:0] = 8'hA5;
        req_write[0]   = 1'b1;
        req            = 2'b01;
        sb.push_back('{2'b01, 8'hC3, 1'b0});
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_ws_psel",    32'(psel),    1);
            check("t4_ws_penable", 32'(penable), 1);
            check("t4_ws_paddr",   32'(paddr),   32'h09);
            check("t4_ws_done",    32'(done),    0);
        end
        tick();
        check("t4_done_late", 32'(done), 32'h1);
        req         = 2'b00;
        wait_states = 0;
        tick();

        // Reset while in ACCESS abandons the transfer and clears the pointer.
        wait_states   = 5;
        req_addr[7:0] = 8'h03;
        req_write[0]  = 1'b0;
        req           = 2'b01;
        tick();
        tick();
        check("t5_in_access", 32'(penable), 1);
        preset = 1'b1;
        req    = 2'b00;
        tick();
        check("t5_rst_psel",    32'(psel),      0);
        check("t5_rst_penable", 32'(penable),   0);
        check("t5_rst_paddr",   32'(paddr),     0);
        check("t5_rst_done",    32'(done),      0);
        check("t5_rst_rdata",   32'(rsp_rdata), 0);
        preset      = 1'b0;
        wait_states = 0;
        tick();
        req_addr[15:8] = 8'h09;
        req_write      = 2'b00;
        sb.push_back('{2'b01, 8'h5A, 1'b0});
        sb.push_back('{2'b10, 8'hA5, 1'b0});
        req = 2'b11;
        wait_done("t5a", 10, n);
        check("t5_first_winner", 32'(done), 32'h1);
        wait_done("t5b", 10, n);
        check("t5_second_winner", 32'(done), 32'h2);
        req = 2'b00;
        tick();
        tick();

`ifdef APB_TIMEOUT_EN
        // Slave never ready: abort after four ACCESS cycles with an error.
        wait_states    = 1000;
        req_addr[15:8] = 8'h03;
        req_write[1]   = 1'b0;
        req            = 2'b10;
        sb.push_back('{2'b10, 8'hA5, 1'b1});
        wait_done("t6", 20, n);
        check("t6_latency", n, 6);
        req = 2'b00;
        tick();
        check("t6_psel_after", 32'(psel), 0);
        wait_states = 0;
        tick();
`endif

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
